pipeio_sw_debounce: RTL and testbench

- Input-conditioning stage for the pipelined computer's memory-mapped IO path.
- Takes the raw board slide switches, synchronises them to the CPU clock and debounces them. Drives the clean 10-bit vector onto the data-memory/IO stage's switch input (io_in_sw).
- Also keeps sticky per-switch rise and fall event flags. These let software detect changes without polling edges.

---
 rtl/pipeio_sw_debounce_if.sv | 24 ++
 rtl/pipeio_sw_debounce.sv | 102 ++++++++++
 tb/tb_pipeio_sw_debounce.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipeio_sw_debounce_if.sv
// Switch-conditioning bundle between the raw board pins / software side and the debounce stage.
// Pure wiring: no latency, no backpressure.
interface pipeio_sw_debounce_if #(
  parameter int NSW = 10
);
  logic [NSW-1:0] sw_raw;
  logic [NSW-1:0] clr_rise;
  logic [NSW-1:0] clr_fall;
  logic [NSW-1:0] sw_clean;
  logic [NSW-1:0] sw_rise;
  logic [NSW-1:0] sw_fall;
  logic           event_pending;
  logic           tick;

  modport master (
    output sw_raw, clr_rise, clr_fall,
    input  sw_clean, sw_rise, sw_fall, event_pending, tick
  );

  modport slave (
    input  sw_raw, clr_rise, clr_fall,
    output sw_clean, sw_rise, sw_fall, event_pending, tick
  );
endinterface

// File: rtl/pipeio_sw_debounce.sv
// Synchronise + debounce the board slide switches and keep sticky rise/fall flags for software.
// sw_clean follows a clean step after 2 + up to STABLE_TICKS*TICK_DIV + 1 cycles; no backpressure.
module pipeio_sw_debounce #(
  parameter int NSW          = 10,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  pipeio_sw_debounce_if.slave   sw_if
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS) + 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [NSW-1:0] sync_q1;
  logic [NSW-1:0] sync_q2;
  logic [NSW-1:0] clean_q;
  logic [NSW-1:0] rise_q;
  logic [NSW-1:0] fall_q;
  logic [NSW-1:0] clean_nxt;
  logic [NSW-1:0] rise_nxt;
  logic [NSW-1:0] fall_nxt;
  logic [CW-1:0]  cnt_q   [NSW];
  logic [CW-1:0]  cnt_nxt [NSW];
  logic [PW-1:0]  pre_cnt;
  logic           tick_q;
  logic           event_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sw_if.sw_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= (pre_cnt == PRE_LAST);
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  // Any cycle where the synced value agrees with the clean value restarts qualification.
  always_comb begin
    clean_nxt = clean_q;
    for (int i = 0; i < NSW; i++) begin
      cnt_nxt[i] = cnt_q[i];
      if (sync_q2[i] == clean_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick_q) begin
        if (cnt_q[i] == CNT_LAST) begin
          clean_nxt[i] = sync_q2[i];
          cnt_nxt[i]   = '0;
        end else begin
          cnt_nxt[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    rise_nxt = (clean_nxt & ~clean_q) | (rise_q & ~sw_if.clr_rise);
    fall_nxt = (~clean_nxt & clean_q) | (fall_q & ~sw_if.clr_fall);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= 1'b0;
      for (int i = 0; i < NSW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      clean_q <= clean_nxt;
      rise_q  <= rise_nxt;
      fall_q  <= fall_nxt;
      event_q <= |(rise_nxt | fall_nxt);
      for (int i = 0; i < NSW; i++) begin
        cnt_q[i] <= cnt_nxt[i];
      end
    end
  end

  assign sw_if.sw_clean      = clean_q;
  assign sw_if.sw_rise       = rise_q;
  assign sw_if.sw_fall       = fall_q;
  assign sw_if.event_pending = event_q;
  assign sw_if.tick          = tick_q;

endmodule

// File: tb/tb_pipeio_sw_debounce.sv
// Bench for pipeio_sw_debounce: directed scenarios plus random switch activity,
// scored cycle by cycle against a tick-counting reference model.
module tb_pipeio_sw_debounce;

  localparam int NSW = 10;
  localparam int TD  = 4;
  localparam int ST  = 3;

  typedef struct packed {
    logic [NSW-1:0] clean;
    logic [NSW-1:0] rise;
    logic [NSW-1:0] fall;
    logic           ev;
    logic           tick;
  } exp_t;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];

  pipeio_sw_debounce_if #(.NSW(NSW)) sw_if ();

  pipeio_sw_debounce #(
    .NSW(NSW), .TICK_DIV(TD), .STABLE_TICKS(ST)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sw_if(sw_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Tick-visible edges among non-reset edges 1..x: edge y sees the strobe
  // when (y-1) is a positive multiple of TD.
  function automatic int ticks_upto(input int x);
    if (x <= 1) return 0;
    return (x - 1) / TD;
  endfunction

  // Reference model: a switch's clean value flips on the tick that completes
  // ST ticks inside one unbroken mismatch run of the 2-cycle-delayed input.
  initial begin : model
    int             e;
    logic [NSW-1:0] s1, s2, m_clean, m_rise, m_fall, nc;
    bit             in_run [NSW];
    int             run_start [NSW];
    logic           m_tick, tv;
    exp_t           x;
    e = 0; s1 = '0; s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0;
    for (int i = 0; i < NSW; i++) begin in_run[i] = 0; run_start[i] = 0; end
    forever begin
      @(posedge clock);
      if (reset) begin
        e = 0; s1 = '0; s2 = '0; m_clean = '0; m_rise = '0; m_fall = '0; m_tick = 1'b0;
        for (int i = 0; i < NSW; i++) in_run[i] = 0;
      end else begin
        e++;
        tv = (e >= 2) && ((e - 1) % TD == 0);
        nc = m_clean;
        for (int i = 0; i < NSW; i++) begin
          if (s2[i] == m_clean[i]) begin
            in_run[i] = 0;
          end else begin
            if (!in_run[i]) begin in_run[i] = 1; run_start[i] = e; end
            if (tv && (ticks_upto(e) - ticks_upto(run_start[i] - 1) == ST)) begin
              nc[i] = s2[i];
              in_run[i] = 0;
            end
          end
        end
        m_rise  = (nc & ~m_clean) | (m_rise & ~sw_if.clr_rise);
        m_fall  = (~nc & m_clean) | (m_fall & ~sw_if.clr_fall);
        m_clean = nc;
        s2      = s1;
        s1      = sw_if.sw_raw;
        m_tick  = (e % TD == 0);
      end
      x.clean = m_clean; x.rise = m_rise; x.fall = m_fall;
      x.ev = |(m_rise | m_fall); x.tick = m_tick;
      exp_q.push_back(x);
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("sb_clean", 32'(sw_if.sw_clean), 32'(x.clean));
        check("sb_rise",  32'(sw_if.sw_rise),  32'(x.rise));
        check("sb_fall",  32'(sw_if.sw_fall),  32'(x.fall));
        check("sb_event", 32'(sw_if.event_pending), 32'(x.ev));
        check("sb_tick",  32'(sw_if.tick), 32'(x.tick));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Waits at negedges until sw_clean[b] == v; returns cycles taken, -1 on timeout.
  task automatic wait_clean(input int b, input logic v, input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clock);
      if (sw_if.sw_clean[b] === v) begin cyc = k; break; end
    end
  endtask

  initial begin : stim
    int cyc;
    int ticks;
    logic [NSW-1:0] flip;
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    sw_if.sw_raw = '0; sw_if.clr_rise = '0; sw_if.clr_fall = '0;
    step(3);
    reset = 1'b0;
    step(12);

    // Clean step on bit 0
    sw_if.sw_raw[0] = 1'b1;
    wait_clean(0, 1'b1, 20, cyc);
    check("step_timeout", 32'(cyc > 0), 32'd1);
    check("step_latency_le15", 32'(cyc <= 15), 32'd1);
    check("step_rise_same_cycle", 32'(sw_if.sw_rise[0]), 32'd1);
    check("step_other_bits", 32'(sw_if.sw_clean[NSW-1:1]), 32'd0);
    @(negedge clock);
    check("step_event_next", 32'(sw_if.event_pending), 32'd1);
    step(1);

    // Bounce on bit 3
    for (int r = 0; r < 4; r++) begin
      sw_if.sw_raw[3] = 1'b1; step(5);
      sw_if.sw_raw[3] = 1'b0; step(3);
    end
    step(16);
    check("bounce_clean3", 32'(sw_if.sw_clean[3]), 32'd0);
    check("bounce_rise3", 32'(sw_if.sw_rise[3]), 32'd0);

    // Clear rise flag, then debounce a fall
    sw_if.clr_rise = 10'h001; step(1);
    sw_if.clr_rise = '0;
    check("clr_rise0", 32'(sw_if.sw_rise[0]), 32'd0);
    check("clr_event", 32'(sw_if.event_pending), 32'd0);
    sw_if.sw_raw[0] = 1'b0;
    wait_clean(0, 1'b0, 20, cyc);
    check("fall_timeout", 32'(cyc > 0), 32'd1);
    check("fall0_set", 32'(sw_if.sw_fall[0]), 32'd1);

    // Set/clear collision on bit 5
    sw_if.clr_fall = 10'h3FF; step(1); sw_if.clr_fall = '0;
    sw_if.sw_raw[5] = 1'b1; step(20);
    sw_if.clr_rise = 10'h3FF; step(1); sw_if.clr_rise = '0;
    sw_if.clr_fall = 10'h020;
    sw_if.sw_raw[5] = 1'b0;
    wait_clean(5, 1'b0, 20, cyc);
    check("coll_timeout", 32'(cyc > 0), 32'd1);
    check("coll_fall5_set", 32'(sw_if.sw_fall[5]), 32'd1);
    @(negedge clock);
    check("coll_fall5_cleared", 32'(sw_if.sw_fall[5]), 32'd0);
    sw_if.clr_fall = '0;
    step(2);

    // Reset in the middle of qualification
    sw_if.sw_raw = 10'h3FF;
    ticks = 0;
    for (int k = 0; k < 20 && ticks < 2; k++) begin
      @(negedge clock);
      if (sw_if.tick) ticks++;
    end
    check("mid_ticks_seen", 32'(ticks), 32'd2);
    step(1);
    reset = 1'b1; step(1);
    check("mid_reset_clean", 32'(sw_if.sw_clean), 32'd0);
    check("mid_reset_flags", 32'(sw_if.sw_rise | sw_if.sw_fall), 32'd0);
    check("mid_reset_ev_tick", 32'({sw_if.event_pending, sw_if.tick}), 32'd0);
    reset = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (sw_if.sw_clean === 10'h3FF) begin cyc = k; break; end
    end
    check("requal_timeout", 32'(cyc > 0), 32'd1);
    check("requal_rise", 32'(sw_if.sw_rise), 32'h3FF);
    step(1);

    // Random activity
    for (int it = 0; it < 1200; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        flip = ($urandom_range(0, 3) == 0) ? NSW'($urandom_range(0, 1023))
                                           : NSW'(1 << $urandom_range(0, NSW-1));
        sw_if.sw_raw = sw_if.sw_raw ^ flip;
      end
      sw_if.clr_rise = ($urandom_range(0, 7) == 0) ? NSW'($urandom_range(0, 1023)) : '0;
      sw_if.clr_fall = ($urandom_range(0, 7) == 0) ? NSW'($urandom_range(0, 1023)) : '0;
      reset = ($urandom_range(0, 299) == 0);
      step(1);
      reset = 1'b0;
      sw_if.clr_rise = '0; sw_if.clr_fall = '0;
      step($urandom_range(0, 19));
    end

    step(2);
    @(negedge clock); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
